// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO fed by CPU stores, serialised as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_AW      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [31:0]        wr_data,
   input  logic               clr_overflow,
   output logic               txd,
   output logic               tx_busy,
   output logic               fifo_full,
   output logic               fifo_empty,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow
);

   localparam int unsigned DEPTH  = 1 << FIFO_AW;
   localparam int unsigned CNT_W  = FIFO_AW + 1;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t              state;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [2:0]          bit_idx;
   logic [7:0]          shift_reg;
   logic [7:0]          fifo_mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr;
   logic [FIFO_AW-1:0]  rd_ptr;
   logic [7:0]          head;
   logic                baud_last;
   logic                pop;
   logic                wr_ok;
   logic                wr_drop;
   logic                unused_wr_data_hi;

   assign unused_wr_data_hi = ^wr_data[31:8];

   assign fifo_full  = (fifo_count == DEPTH_CNT);
   assign fifo_empty = (fifo_count == '0);
   assign tx_busy    = (state != IDLE) || !fifo_empty;
   assign head       = fifo_mem[rd_ptr];
   assign baud_last  = (baud_cnt == BAUD_LAST);

   // The head is consumed when the line is free, or on the final stop cycle for a gapless next frame.
   assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
   assign wr_ok   = wr_en && (!fifo_full || pop);
   assign wr_drop = wr_en && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         fifo_mem[wr_ptr] <= wr_data[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow (a set wins over a coincident clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= FIFO_AW'(wr_ptr + 1'b1);
         end
         if (pop) begin
            rd_ptr <= FIFO_AW'(rd_ptr + 1'b1);
         end
         case ({wr_ok, pop})
            2'b10:   fifo_count <= CNT_W'(fifo_count + 1'b1);
            2'b01:   fifo_count <= CNT_W'(fifo_count - 1'b1);
            default: fifo_count <= fifo_count;
         endcase
         if (wr_drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   logic parity_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_bit <= 1'b0;
      end else if (pop) begin
         parity_bit <= ^head;
      end
   end
`endif

   // Frame sequencer; txd is registered, so each bit appears the cycle after its boundary edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         txd       <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift_reg <= head;
                  baud_cnt  <= '0;
                  state     <= START;
                  txd       <= 1'b0;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  txd      <= shift_reg[0];
               end else begin
                  baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     txd   <= parity_bit;
`else
                     state <= STOP;
                     txd   <= 1'b1;
`endif
                  end else begin
                     bit_idx <= 3'(bit_idx + 1'b1);
                     txd     <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= STOP;
                  txd      <= 1'b1;
               end else begin
                  baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
               end
            end
`endif
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg <= head;
                     state     <= START;
                     txd       <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed vector table, hand-written frame sequences,
// and randomized traffic checked every cycle against a frame-timeline reference model.
module tb_uart_tx_mmio;

   localparam int unsigned CPB     = 16;
   localparam int unsigned FIFO_AW = 2;
   localparam int unsigned DEPTH   = 1 << FIFO_AW;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS   = 11;
`else
   localparam int unsigned NBITS   = 10;
`endif
   localparam int unsigned FRAME   = NBITS * CPB;
   localparam int unsigned TR      = 800;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               wr_en = 1'b0;
   logic [31:0]        wr_data = '0;
   logic               clr_overflow = 1'b0;
   logic               txd;
   logic               tx_busy;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_AW:0]   fifo_count;
   logic               overflow;

   uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_overflow(clr_overflow),
      .txd(txd), .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int nchecks = 0;
   int nerrors = 0;
   int cyc = 0;
   int base = 0;

   // Reference model: a byte queue plus the position inside the frame currently on the line.
   logic [7:0] mq[$];
   bit         m_active = 0;
   int         m_elapsed = 0;
   logic [7:0] m_cur = '0;
   bit         m_ovf = 0;

   logic       tr_txd  [TR];
   logic       tr_busy [TR];
   logic [2:0] tr_cnt  [TR];

   function automatic logic line_bit(input logic [7:0] b, input int e);
      int k;
      k = e / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic logic [7:0] model_out();
      logic mt;
      logic [2:0] mc;
      mt = m_active ? line_bit(m_cur, m_elapsed) : 1'b1;
      mc = 3'(mq.size());
      return {mt, (m_active || mq.size() != 0), (mq.size() == DEPTH), (mq.size() == 0), m_ovf, mc};
   endfunction

   function automatic void model_edge(input logic r, input logic w, input logic [31:0] d, input logic c);
      bit full, pop;
      if (r) begin
         mq.delete();
         m_active  = 0;
         m_elapsed = 0;
         m_ovf     = 0;
         return;
      end
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && (!m_active || m_elapsed == FRAME - 1);
      if (pop) begin
         m_cur     = mq.pop_front();
         m_active  = 1;
         m_elapsed = 0;
      end else if (m_active) begin
         if (m_elapsed == FRAME - 1) m_active = 0;
         else m_elapsed++;
      end
      if (w && (!full || pop)) mq.push_back(d[7:0]);
      if (w && full && !pop) m_ovf = 1;
      else if (c) m_ovf = 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock: drive at negedge, update the model at the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic w, input logic [31:0] d, input logic c);
      int off;
      @(negedge clk);
      rst = r; wr_en = w; wr_data = d; clr_overflow = c;
      @(posedge clk);
      model_edge(r, w, d, c);
      #1;
      cyc++;
      check("model", 32'({txd, tx_busy, fifo_full, fifo_empty, overflow, fifo_count}), 32'(model_out()));
      off = cyc - base;
      if (off >= 0 && off < int'(TR)) begin
         tr_txd[off]  = txd;
         tr_busy[off] = tx_busy;
         tr_cnt[off]  = fifo_count;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   typedef struct {
      logic        rst;
      logic        wr;
      logic [31:0] data;
      logic        clr;
      logic [7:0]  exp;   // {txd, busy, full, empty, overflow, count[2:0]}
   } vec_t;

   vec_t vecs[12];

   initial begin
      int zeros;
      int mid;

      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 8'b1_0_0_1_0_000};
      vecs[1]  = '{1'b0, 1'b1, 32'hDEAD_BE11, 1'b0, 8'b1_1_0_0_0_001};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0022, 1'b0, 8'b0_1_0_0_0_001};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0033, 1'b0, 8'b0_1_0_0_0_010};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0044, 1'b0, 8'b0_1_0_0_0_011};
      vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_FF55, 1'b0, 8'b0_1_1_0_0_100};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_0066, 1'b0, 8'b0_1_1_0_1_100};
      vecs[7]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'b0_1_1_0_0_100};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_0077, 1'b1, 8'b0_1_1_0_1_100};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'b0_1_1_0_0_100};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 8'b1_0_0_1_0_000};
      vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'b1_0_0_1_0_000};

      // Directed vectors: fill, drop, sticky overflow, set-beats-clear, reset.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].clr);
         check($sformatf("vec%0d", i),
               32'({txd, tx_busy, fifo_full, fifo_empty, overflow, fifo_count}), 32'(vecs[i].exp));
      end

      // Long idle after reset release.
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         check("idle", 32'({txd, tx_busy, fifo_empty, overflow}), 32'(4'b1010));
      end

      // Single byte 0x55: start edge, mid-bit samples, busy release.
      base = cyc + 1;
      step(1'b0, 1'b1, 32'h0000_0055, 1'b0);
      idle(FRAME + 5);
      check("s55_pre_fall", 32'(tr_txd[0]), 32'(1'b1));
      check("s55_fall", 32'(tr_txd[1]), 32'(1'b0));
      for (int j = 0; j < 9; j++) begin
         mid = 1 + j * CPB + CPB / 2;
         check($sformatf("s55_bit%0d", j), 32'(tr_txd[mid]), 32'((j == 0) ? 1'b0 : ((j % 2) == 1)));
      end
      check("s55_stop", 32'(tr_txd[1 + (NBITS - 1) * CPB + CPB / 2]), 32'(1'b1));
      check("s55_busy_last", 32'(tr_busy[FRAME]), 32'(1'b1));
      check("s55_busy_drop", 32'(tr_busy[FRAME + 1]), 32'(1'b0));

      // Three back-to-back frames with no idle gap.
      base = cyc + 1;
      step(1'b0, 1'b1, 32'h0000_0041, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0042, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0043, 1'b0);
      idle(3 * FRAME + 5);
      check("b2b_cnt0", 32'(tr_cnt[0]), 32'd1);
      check("b2b_cnt1", 32'(tr_cnt[1]), 32'd1);
      check("b2b_cnt2", 32'(tr_cnt[2]), 32'd2);
      check("b2b_cnt_pop2", 32'(tr_cnt[FRAME + 1]), 32'd1);
      check("b2b_cnt_pop3", 32'(tr_cnt[2 * FRAME + 1]), 32'd0);
      check("b2b_stop1", 32'(tr_txd[FRAME]), 32'(1'b1));
      check("b2b_start2", 32'(tr_txd[FRAME + 1]), 32'(1'b0));
      check("b2b_start3", 32'(tr_txd[2 * FRAME + 1]), 32'(1'b0));
      check("b2b_busy_last", 32'(tr_busy[3 * FRAME]), 32'(1'b1));
      check("b2b_busy_drop", 32'(tr_busy[3 * FRAME + 1]), 32'(1'b0));

      // Reset in the middle of the data bits of 0xA5 with two bytes queued.
      base = cyc + 1;
      step(1'b0, 1'b1, 32'h0000_00A5, 1'b0);
      step(1'b0, 1'b1, 32'h0000_00B6, 1'b0);
      step(1'b0, 1'b1, 32'h0000_00C7, 1'b0);
      idle(60);
      check("rst_mid_cnt_before", 32'(fifo_count), 32'd2);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("rst_mid_txd", 32'(txd), 32'(1'b1));
      check("rst_mid_cnt", 32'(fifo_count), 32'd0);
      zeros = 0;
      for (int i = 0; i < 400; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         if (txd !== 1'b1) zeros++;
      end
      check("rst_mid_no_frames", 32'(zeros), 32'd0);
      check("rst_mid_busy", 32'(tx_busy), 32'(1'b0));

`ifdef UART_TX_PARITY_EN
      // Parity bit and 11-bit frame length.
      base = cyc + 1;
      step(1'b0, 1'b1, 32'h0000_0007, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0003, 1'b0);
      idle(2 * FRAME + 5);
      check("par_07", 32'(tr_txd[1 + 9 * CPB + CPB / 2]), 32'(1'b1));
      check("par_03", 32'(tr_txd[1 + 176 + 9 * CPB + CPB / 2]), 32'(1'b0));
      check("par_stop1", 32'(tr_txd[176]), 32'(1'b1));
      check("par_start2", 32'(tr_txd[177]), 32'(1'b0));
      check("par_busy_last", 32'(tr_busy[352]), 32'(1'b1));
      check("par_busy_drop", 32'(tr_busy[353]), 32'(1'b0));
`endif

      // Randomized traffic with write bursts, clears and rare resets.
      begin
         int burst;
         logic r, w, c;
         burst = 0;
         for (int i = 0; i < 6000; i++) begin
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = 6;
            r = ($urandom_range(0, 1499) == 0);
            w = (burst > 0) || ($urandom_range(0, 49) == 0);
            c = ($urandom_range(0, 149) == 0);
            if (burst > 0) burst--;
            step(r, w, $urandom, c);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
